// File: rtl/explosion_logic.sv
// Blast propagation over the tile map: decodes the bomb tile, probes four
// directions, frees soft blocks, and holds the flame set for a few ticks.
module explosion_logic #(
    parameter int NUM_ROW       = 11,
    parameter int NUM_COL       = 19,
    parameter int MAP_MEM_WIDTH = 2,
    parameter int BLAST_RADIUS  = 2,
    parameter int FLAME_TICKS   = 2,
    localparam int ADDR_WIDTH   = $clog2(NUM_ROW * NUM_COL),
    localparam int MAX_FLAMES   = 1 + 4 * BLAST_RADIUS,
    localparam int COUNT_WIDTH  = $clog2(MAX_FLAMES + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic                     trigger_explosion,
    input  logic [ADDR_WIDTH-1:0]    explode_addr,
    output logic [ADDR_WIDTH-1:0]    rd_addr,
    input  logic [MAP_MEM_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0]    write_addr,
    output logic [MAP_MEM_WIDTH-1:0] write_data,
    output logic                     write_en,
    output logic                     busy,
    output logic                     flame_active,
    output logic [COUNT_WIDTH-1:0]   flame_count,
    input  logic [ADDR_WIDTH-1:0]    query_addr,
    output logic                     query_hit,
    output logic                     done
);

    localparam int AW = ADDR_WIDTH;
    localparam int XW = ADDR_WIDTH + 1;
    localparam int TW = $clog2(FLAME_TICKS + 1);

    localparam logic [XW-1:0] ROWS = XW'(NUM_ROW);
    localparam logic [XW-1:0] COLS = XW'(NUM_COL);
    localparam logic [XW-1:0] RAD  = XW'(BLAST_RADIUS);
    localparam logic [TW-1:0] LAST_TICK = TW'(FLAME_TICKS - 1);
    localparam logic [COUNT_WIDTH-1:0] MAXC = COUNT_WIDTH'(MAX_FLAMES);

    localparam logic [MAP_MEM_WIDTH-1:0] FREE = MAP_MEM_WIDTH'(0);
    localparam logic [MAP_MEM_WIDTH-1:0] SOFT = MAP_MEM_WIDTH'(2);

    typedef enum logic [2:0] {IDLE, DECODE, STEP, WAIT, EVAL, HOLD} state_t;
    typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;

    state_t state;
    dir_t   dir;

    logic [AW-1:0]          base;
    logic [AW-1:0]          rem;
    logic [XW-1:0]          row;
    logic [XW-1:0]          col;
    logic [XW-1:0]          k;
    logic [AW-1:0]          flames [MAX_FLAMES];
    logic [COUNT_WIDTH-1:0] count;
    logic [TW-1:0]          ticks;

    logic          oob;
    logic [AW-1:0] target;
    logic          keeps_going;
    logic          flamed;

    // Bounds come from row/col so a blast never wraps across a row end
    always_comb begin
        oob    = 1'b0;
        target = base;
        unique case (dir)
            UP: begin
                oob    = row < k;
                target = base - AW'(k * COLS);
            end
            DOWN: begin
                oob    = (row + k) >= ROWS;
                target = base + AW'(k * COLS);
            end
            LEFT: begin
                oob    = col < k;
                target = base - AW'(k);
            end
            RIGHT: begin
                oob    = (col + k) >= COLS;
                target = base + AW'(k);
            end
        endcase
    end

    always_comb begin
        flamed      = (rd_data == FREE) || (rd_data == SOFT);
        keeps_going = (rd_data == FREE) && (k < RAD);
    end

    always_comb begin
        query_hit = 1'b0;
        for (int i = 0; i < MAX_FLAMES; i++) begin
            if ((COUNT_WIDTH'(i) < count) && (flames[i] == query_addr)) begin
                query_hit = 1'b1;
            end
        end
        query_hit = query_hit & flame_active;
    end

    assign write_en     = (state == EVAL) && (rd_data == SOFT);
    assign write_addr   = rd_addr;
    assign write_data   = '0;
    assign busy         = (state != IDLE);
    assign flame_active = (state == HOLD);
    assign flame_count  = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            dir     <= UP;
            base    <= '0;
            rem     <= '0;
            row     <= '0;
            col     <= '0;
            k       <= '0;
            count   <= '0;
            ticks   <= '0;
            rd_addr <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (trigger_explosion) begin
                        base  <= explode_addr;
                        rem   <= explode_addr;
                        row   <= '0;
                        count <= '0;
                        ticks <= '0;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    if (XW'(rem) >= COLS) begin
                        rem <= rem - AW'(NUM_COL);
                        row <= row + XW'(1);
                    end else begin
                        col       <= XW'(rem);
                        flames[0] <= base;
                        count     <= COUNT_WIDTH'(1);
                        dir       <= UP;
                        k         <= XW'(1);
                        state     <= STEP;
                    end
                end
                STEP: begin
                    if (!oob) begin
                        rd_addr <= target;
                        state   <= WAIT;
                    end else if (dir == RIGHT) begin
                        state <= HOLD;
                    end else begin
                        dir <= dir_t'(dir + 2'd1);
                        k   <= XW'(1);
                    end
                end
                WAIT: state <= EVAL;
                EVAL: begin
                    if (flamed && (count < MAXC)) begin
                        flames[count] <= rd_addr;
                        count         <= count + COUNT_WIDTH'(1);
                    end
                    if (keeps_going) begin
                        k     <= k + XW'(1);
                        state <= STEP;
                    end else if (dir == RIGHT) begin
                        state <= HOLD;
                    end else begin
                        dir   <= dir_t'(dir + 2'd1);
                        k     <= XW'(1);
                        state <= STEP;
                    end
                end
                HOLD: begin
                    if (tick) begin
                        if (ticks == LAST_TICK) begin
                            ticks <= '0;
                            count <= '0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            ticks <= ticks + TW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_explosion_logic.sv
// Directed bench for explosion_logic: row/col reference blast model plus a
// scoreboard of expected map writes popped as the DUT issues them.
module tb_explosion_logic;

    localparam int NR = 11;
    localparam int NC = 19;
    localparam int R  = 2;
    localparam int NT = NR * NC;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       trigger_explosion;
    logic [7:0] explode_addr;
    logic [7:0] rd_addr;
    logic [1:0] rd_data;
    logic [7:0] write_addr;
    logic [1:0] write_data;
    logic       write_en;
    logic       busy;
    logic       flame_active;
    logic [3:0] flame_count;
    logic [7:0] query_addr;
    logic       query_hit;
    logic       done;

    logic [1:0] mem [NT];
    bit         exp_flame [NT];
    int         exp_wr [$];
    int         wr_exp;
    int         checks = 0;
    int         errors = 0;

    explosion_logic dut (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .trigger_explosion(trigger_explosion),
        .explode_addr(explode_addr),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .write_addr(write_addr),
        .write_data(write_data),
        .write_en(write_en),
        .busy(busy),
        .flame_active(flame_active),
        .flame_count(flame_count),
        .query_addr(query_addr),
        .query_hit(query_hit),
        .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= mem[rd_addr];

    always @(negedge clk) begin
        if (write_en === 1'b1) begin
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $error("FAIL write_unexpected: observed addr %0d expected no write",
                       write_addr);
            end else begin
                wr_exp = exp_wr.pop_front();
                assert ({write_data, write_addr} === {2'b00, wr_exp[7:0]}) else begin
                    errors++;
                    $error("FAIL write_match: observed data %0d addr %0d expected data 0 addr %0d",
                           write_data, write_addr, wr_exp);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill_free();
        for (int i = 0; i < NT; i++) mem[i] = 2'd0;
    endtask

    // Reference blast: walks row/col directly, returns cycles to HOLD
    task automatic model(input int addr, output int lat, output int cnt);
        int r, c, tr, tc, t;
        r = addr / NC;
        c = addr % NC;
        for (int i = 0; i < NT; i++) exp_flame[i] = 1'b0;
        exp_flame[addr] = 1'b1;
        cnt = 1;
        lat = r + 1;
        for (int d = 0; d < 4; d++) begin
            for (int kk = 1; kk <= R; kk++) begin
                tr = r;
                tc = c;
                case (d)
                    0: tr = r - kk;
                    1: tr = r + kk;
                    2: tc = c - kk;
                    default: tc = c + kk;
                endcase
                if (tr < 0 || tr >= NR || tc < 0 || tc >= NC) begin
                    lat += 1;
                    break;
                end
                lat += 3;
                t = tr * NC + tc;
                if (mem[t] == 2'd0) begin
                    exp_flame[t] = 1'b1;
                    cnt++;
                end else if (mem[t] == 2'd2) begin
                    exp_flame[t] = 1'b1;
                    cnt++;
                    exp_wr.push_back(t);
                    break;
                end else begin
                    break;
                end
            end
        end
    endtask

    task automatic start(input int addr);
        @(negedge clk);
        trigger_explosion = 1'b1;
        explode_addr = 8'(addr);
        @(negedge clk);
        trigger_explosion = 1'b0;
    endtask

    task automatic wait_hold(output int cyc);
        cyc = 0;
        while (flame_active !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("wait_hold", flame_active, 1);
    endtask

    task automatic sweep(input string tag);
        int mism;
        mism = 0;
        for (int i = 0; i < NT; i++) begin
            query_addr = 8'(i);
            #1;
            if (query_hit !== exp_flame[i]) mism++;
        end
        check({tag, "_sweep_mismatches"}, mism, 0);
    endtask

    task automatic query(input string tag, input int addr, input logic exp);
        query_addr = 8'(addr);
        #1;
        check(tag, query_hit, exp);
    endtask

    task automatic run(input int addr, input int exp_cnt, input string tag);
        int lat, cnt, cyc;
        model(addr, lat, cnt);
        start(addr);
        wait_hold(cyc);
        check({tag, "_latency"}, cyc, lat);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_count"}, flame_count, exp_cnt);
        check({tag, "_count_model"}, flame_count, cnt);
        check({tag, "_writes_left"}, exp_wr.size(), 0);
        sweep(tag);
    endtask

    task automatic ticks_done(input string tag);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check({tag, "_tick1_hold"}, flame_active, 1);
        check({tag, "_tick1_done"}, done, 0);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check({tag, "_done"}, done, 1);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_active"}, flame_active, 0);
        check({tag, "_idle_count"}, flame_count, 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int lat, cnt, cyc, nbusy;
        rst = 1'b1;
        tick = 1'b0;
        trigger_explosion = 1'b0;
        explode_addr = '0;
        query_addr = '0;
        fill_free();
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_active", flame_active, 0);
        check("rst_count", flame_count, 0);
        check("rst_done", done, 0);
        check("rst_wen", write_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_wr_addr", write_addr, 0);
        check("rst_hit", query_hit, 0);
        rst = 1'b0;

        run(104, 9, "free");
        query("free_q66", 66, 1'b1);
        query("free_q67", 67, 1'b0);
        ticks_done("free");
        query("free_q66_after", 66, 1'b0);

        mem[105] = 2'd2;
        run(104, 8, "soft");
        query("soft_q105", 105, 1'b1);
        query("soft_q106", 106, 1'b0);
        ticks_done("soft");
        fill_free();

        mem[85]  = 2'd1;
        mem[103] = 2'd3;
        run(104, 5, "hard");
        query("hard_q85", 85, 1'b0);
        query("hard_q66", 66, 1'b0);
        query("hard_q103", 103, 1'b0);
        query("hard_q102", 102, 1'b0);
        ticks_done("hard");
        fill_free();

        run(0, 5, "corner0");
        query("corner0_q38", 38, 1'b1);
        ticks_done("corner0");

        run(18, 5, "corner18");
        query("corner18_q19", 19, 1'b0);
        query("corner18_q16", 16, 1'b1);
        ticks_done("corner18");

        // Extra triggers while busy and a stray tick before HOLD
        model(104, lat, cnt);
        start(104);
        cyc = 0;
        nbusy = 0;
        while (flame_active !== 1'b1 && cyc < 200) begin
            trigger_explosion = (cyc == 2 || cyc == 10);
            explode_addr = 8'd0;
            tick = (cyc == 12);
            if (busy !== 1'b1) nbusy++;
            @(negedge clk);
            cyc++;
        end
        trigger_explosion = 1'b0;
        tick = 1'b0;
        check("ign_latency", cyc, lat);
        check("ign_busy_drop", nbusy, 0);
        @(negedge clk);
        trigger_explosion = 1'b1;
        @(negedge clk);
        trigger_explosion = 1'b0;
        check("ign_hold_busy", busy, 1);
        check("ign_hold_active", flame_active, 1);
        check("ign_count", flame_count, cnt);
        sweep("ign");
        ticks_done("ign");

        run(104, 9, "rsthold");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rsthold_busy", busy, 0);
        check("rsthold_active", flame_active, 0);
        check("rsthold_count", flame_count, 0);
        check("rsthold_done", done, 0);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check("rsthold_no_done", done, 0);
        check("rsthold_idle", busy, 0);
        run(18, 5, "after_rst");
        ticks_done("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/explosion_logic.md
Name: explosion_logic

Overview:
- Downstream of bomb_logic. Consumes its `trigger_explosion` pulse and the detonated bomb's tile address.
- Propagates the blast in four directions up to BLAST_RADIUS tiles over the tile map memory. Destroys soft blocks by writing FREE. Records every flame tile.
- Holds the flames for FLAME_TICKS game ticks, then clears them.
- Provides a flame-query port used by player hit detection and the renderer.

Parameters:
- NUM_ROW, 11, map rows
- NUM_COL, 19, map columns
- MAP_MEM_WIDTH, 2, tile code width
- BLAST_RADIUS, 2, max flame length per direction (1..4)
- FLAME_TICKS, 2, tick pulses flames stay visible (>=1)
- Derived: ADDR_WIDTH = $clog2(NUM_ROW*NUM_COL); MAX_FLAMES = 1+4*BLAST_RADIUS

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- tick  in  1  one-cycle game-tick strobe
- trigger_explosion  in  1  one-cycle detonation pulse from bomb_logic
- explode_addr  in  ADDR_WIDTH  linear address (row*NUM_COL+col) of detonated bomb; valid with trigger
- rd_addr  out  ADDR_WIDTH  map read address; memory has 1-cycle synchronous read
- rd_data  in  MAP_MEM_WIDTH  map read data
- write_addr  out  ADDR_WIDTH  map write address
- write_data  out  MAP_MEM_WIDTH  map write data (always FREE=0)
- write_en  out  1  map write strobe, one cycle per write
- busy  out  1  high in every state except IDLE
- flame_active  out  1  high in HOLD
- flame_count  out  $clog2(MAX_FLAMES+1)  number of recorded flame tiles
- query_addr  in  ADDR_WIDTH  tile to test
- query_hit  out  1  combinational; 1 iff flame_active and query_addr matches a recorded flame
- done  out  1  one-cycle pulse on HOLD->IDLE

Behaviour:
- Tile codes: 0 FREE, 1 HARD, 2 SOFT, 3 BOMB.
- Reset values: all outputs 0, rd_addr 0, write_addr 0, flame list empty, state IDLE.
- Reset in any state aborts immediately. No pending write is issued and all flames are cleared.
- IDLE: on trigger_explosion, latch explode_addr, clear the flame list, go to DECODE. A trigger in any other state is ignored; it is not queued.
- DECODE (row/col extraction by repeated subtraction):
  - Each cycle, if rem >= NUM_COL: rem -= NUM_COL, row++.
  - Otherwise col = rem. Record the center as flame 0 and go to STEP with dir=UP, k=1.
  - Takes row+1 cycles.
  - The center tile is not written; bomb_logic frees it.
- Direction order: UP (row-k), DOWN (row+k), LEFT (col-k), RIGHT (col+k).
- STEP:
  - If the target is out of bounds (row-k<0, row+k>=NUM_ROW, col-k<0, col+k>=NUM_COL), end the direction with no read.
  - Bounds use row/col, never raw address arithmetic. No wrap across row ends.
  - Otherwise drive rd_addr = target and go to WAIT.
- WAIT: one cycle; then EVAL samples rd_data.
- EVAL:
  - FREE: record flame. If k<BLAST_RADIUS, k++ and go to STEP; else end the direction.
  - SOFT: record flame; write_en=1, write_addr=target, write_data=0 in this cycle; end the direction.
  - HARD or BOMB: no flame; end the direction.
- Ending a direction: advance dir, reset k=1. After RIGHT, go to HOLD.
- Each probed tile costs 3 cycles (STEP, WAIT, EVAL). An out-of-bounds STEP costs 1 cycle.
- HOLD: flame_active=1 and query_hit is live. Count tick pulses. On the FLAME_TICKS-th tick, go to IDLE next cycle with done=1 for that cycle. The flame list and flame_count clear to 0.
- flame_count increments with each recorded flame and never exceeds MAX_FLAMES.
- write_en is asserted only in EVAL. At most one write per direction per explosion.
- A tick arriving outside HOLD is ignored.

Test Plan:
- All FREE, explode_addr=104 (row5,col9), R=2 -> flames {104,85,66,123,142,103,102,105,106}, flame_count=9, no write_en; query 66->hit, 67->miss; done after 2 ticks, then query 66->miss.
- SOFT at 105, FREE elsewhere, addr 104 -> exactly one write_en (addr 105, data 0); 105 flamed, 106 not; count=8.
- HARD at 85, BOMB at 103 -> 85, 66, 103, 102 not flamed; count=5; no write_en.
- Corner addr=0 -> up/left skipped without reads; flames {0,19,38,1,2}, count=5. addr=18 (row0,col18) -> 19 never flamed (no wrap); flames {18,37,56,17,16}.
- Second trigger during DECODE/STEP/HOLD -> ignored; flame list unchanged; busy stays 1 until done.
- rst asserted in HOLD -> next cycle busy=0, flame_active=0, flame_count=0, no done pulse; a new trigger afterward works normally.
